hash_lookup: RTL

- Read-side search engine for the 32-entry nibble-hash store with linear probing.
- The store inserts a byte at slot (high nibble + low nibble) and, on collision, probes forward to the next free slot, wrapping from 31 to 0.
- Given a key byte, this block computes the same home slot and issues probe reads until one of three things happens: the key matches, an empty slot is read, or all slots have been visited.
- It returns found/address to the system controller and owns the store's read port; the write side stays with the insert path.

---
 rtl/hash_lookup_pkg.sv | 21 ++
 rtl/hash_lookup_if.sv | 27 ++
 rtl/hash_lookup_hash.sv | 9 +
 rtl/hash_lookup.sv | 103 ++++++++++
 4 files changed

// File: rtl/hash_lookup_pkg.sv
// Shared definitions for the nibble-hash store: geometry, home-slot hash and
// lookup FSM state encodings.
package hash_store_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [1:0] lk_state_t;

    localparam lk_state_t ST_IDLE  = 2'd0;
    localparam lk_state_t ST_ISSUE = 2'd1;
    localparam lk_state_t ST_WAIT  = 2'd2;
    localparam lk_state_t ST_DONE  = 2'd3;

    // Zero-extended nibble sum; for 8-bit keys the result is 0..30.
    function automatic logic [ADDR_W-1:0] home_slot(input logic [DATA_W-1:0] k);
        return ADDR_W'(k[DATA_W-1:DATA_W/2]) + ADDR_W'(k[DATA_W/2-1:0]);
    endfunction

endpackage

// File: rtl/hash_lookup_if.sv
// Request/result handshake plus store read port of the lookup engine.
interface hash_lookup_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              start;
    logic [DATA_W-1:0] key;
    logic              busy;
    logic              done;
    logic              found;
    logic [ADDR_W-1:0] found_addr;
    logic [ADDR_W:0]   probes;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;

    modport slave (
        input  start, key, mem_rdata, mem_valid,
        output busy, done, found, found_addr, probes, mem_read, mem_addr
    );

    modport master (
        output start, key, mem_rdata, mem_valid,
        input  busy, done, found, found_addr, probes, mem_read, mem_addr
    );
endinterface

// File: rtl/hash_lookup_hash.sv
// Combinational key -> home slot, reusable by the insert path.
module nibble_hash
    import hash_store_pkg::*;
(
    input  logic [DATA_W-1:0] key,
    output logic [ADDR_W-1:0] home
);
    assign home = home_slot(key);
endmodule

// File: rtl/hash_lookup.sv
// Linear-probe search over the nibble-hash store; owns the store read port and
// reports found/address/probe count for one key per request.
module hash_lookup #(
    parameter int DATA_W   = hash_store_pkg::DATA_W,
    parameter int ADDR_W   = hash_store_pkg::ADDR_W,
    parameter int DEPTH    = hash_store_pkg::DEPTH,
    parameter int READ_LAT = 0
) (
    input  logic          clk,
    input  logic          reset,
    hash_lookup_if.slave  bus
);
    import hash_store_pkg::*;

    lk_state_t         state_q, state_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   probes_q, probes_d;
    logic              found_q, found_d;

    logic [ADDR_W-1:0] home;
    logic [ADDR_W:0]   probes_nx;
    logic              eval;
    logic              hit;

    nibble_hash u_hash (
        .key  (bus.key),
        .home (home)
    );

    // Slot data is judged in ISSUE for a combinational store, in WAIT otherwise.
    assign eval      = (READ_LAT == 0) ? (state_q == ST_ISSUE) : (state_q == ST_WAIT);
    assign hit       = bus.mem_valid && (bus.mem_rdata == key_q);
    assign probes_nx = probes_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        ptr_d    = ptr_q;
        addr_d   = addr_q;
        probes_d = probes_q;
        found_d  = found_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    key_d    = bus.key;
                    ptr_d    = home;
                    probes_d = '0;
                    found_d  = 1'b0;
                    addr_d   = '0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (state_q == ST_ISSUE && READ_LAT != 0) state_d = ST_WAIT;
                if (eval) begin
                    probes_d = probes_nx;
                    if (hit) begin
                        found_d = 1'b1;
                        addr_d  = ptr_q;
                        state_d = ST_DONE;
                    end else if (!bus.mem_valid || probes_nx == (ADDR_W+1)'(DEPTH)) begin
                        // Empty slot ends the chain; a full sweep means the table is full.
                        state_d = ST_DONE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            key_q    <= '0;
            ptr_q    <= '0;
            addr_q   <= '0;
            probes_q <= '0;
            found_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            probes_q <= probes_d;
            found_q  <= found_d;
        end
    end

    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.mem_read   = (state_q == ST_ISSUE);
    assign bus.mem_addr   = ptr_q;
    assign bus.found      = found_q;
    assign bus.found_addr = addr_q;
    assign bus.probes     = probes_q;

endmodule
